// File: rtl/to_unsigned_buf_pkg.sv
// Shared sample-format definitions for the codec data paths: silence code and the
// signed <-> unsigned code mapping used on both the ADC and DAC sides.
package to_unsigned_buf_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] SILENCE_CODE = 16'h8000;

  // Signed sample -> unsigned DAC code; negative samples fold onto the lower half.
  function automatic logic [SAMPLE_W-1:0] map_s2u(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] o;
    o[SAMPLE_W-1]   = ~s[SAMPLE_W-1];
    o[SAMPLE_W-2:0] = s[SAMPLE_W-1] ? ~s[SAMPLE_W-2:0] : s[SAMPLE_W-2:0];
    return o;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] map_u2s(input logic [SAMPLE_W-1:0] u);
    logic signed [SAMPLE_W-1:0] s;
    s[SAMPLE_W-1]   = ~u[SAMPLE_W-1];
    s[SAMPLE_W-2:0] = u[SAMPLE_W-1] ? u[SAMPLE_W-2:0] : ~u[SAMPLE_W-2:0];
    return s;
  endfunction

endpackage

// File: rtl/to_unsigned_buf_if.sv
// Bus between the DSP output / DAC serializer side (master) and the return buffer (slave).
interface to_unsigned_buf_if import to_unsigned_buf_pkg::*; #(
  parameter int DEPTH = 8
) ();
  localparam int AW = $clog2(DEPTH);

  logic                        we;
  logic signed [SAMPLE_W-1:0]  i_data;
  logic                        req;
  logic                        clr;
  logic [SAMPLE_W-1:0]         o_data;
  logic                        re;
  logic                        full;
  logic                        empty;
  logic [AW:0]                 level;
  logic                        ovf;
  logic                        udr;

  modport master (
    output we, i_data, req, clr,
    input  o_data, re, full, empty, level, ovf, udr
  );

  modport slave (
    input  we, i_data, req, clr,
    output o_data, re, full, empty, level, ovf, udr
  );
endinterface

// File: rtl/to_unsigned_buf_sync_fifo.sv
// Generic DEPTH x DATA_W register FIFO with registered level/full/empty.
// The caller must not read when empty nor write when full without a same-cycle read.
module to_unsigned_buf_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       level_q, level_d;
  logic              full_q, empty_q;

  always_comb begin
    level_d = level_q + {{AW{1'b0}}, wr_en_i} - {{AW{1'b0}}, rd_en_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_en_i) wptr_q <= wptr_q + 1'b1;
      if (rd_en_i) rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == (AW+1)'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/to_unsigned_buf.sv
// DAC return buffer: maps signed DSP samples to unsigned codes, queues them, and
// serves one code per serializer request with silence substitution on underrun.
module to_unsigned_buf import to_unsigned_buf_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  to_unsigned_buf_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] code;
  logic [SAMPLE_W-1:0] rd_data;
  logic                fifo_full, fifo_empty;
  logic [AW:0]         fifo_level;
  logic                do_wr, do_rd;

  logic [SAMPLE_W-1:0] o_data_q, o_data_d;
  logic                re_q, re_d;
  logic                ovf_q, ovf_d;
  logic                udr_q, udr_d;

  assign code  = map_s2u(bus.i_data);
  // A read on a full FIFO frees the slot the concurrent write lands in.
  assign do_rd = bus.req & ~fifo_empty;
  assign do_wr = bus.we & (~fifo_full | bus.req);

  to_unsigned_buf_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (do_wr),
    .wr_data_i (code),
    .rd_en_i   (do_rd),
    .rd_data_o (rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  always_comb begin
    o_data_d = o_data_q;
    if (bus.req) o_data_d = fifo_empty ? SILENCE_CODE : rd_data;
    re_d  = bus.req;
    ovf_d = (bus.we & fifo_full & ~bus.req) | (ovf_q & ~bus.clr);
    udr_d = (bus.req & fifo_empty) | (udr_q & ~bus.clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_data_q <= SILENCE_CODE;
      re_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      o_data_q <= o_data_d;
      re_q     <= re_d;
      ovf_q    <= ovf_d;
      udr_q    <= udr_d;
    end
  end

  assign bus.o_data = o_data_q;
  assign bus.re     = re_q;
  assign bus.full   = fifo_full;
  assign bus.empty  = fifo_empty;
  assign bus.level  = fifo_level;
  assign bus.ovf    = ovf_q;
  assign bus.udr    = udr_q;

endmodule

// File: tb/tb_to_unsigned_buf.sv
// Bench for to_unsigned_buf: directed vector table followed by random traffic
// checked against a queue-based reference model.
module tb_to_unsigned_buf;
  import to_unsigned_buf_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  to_unsigned_buf_if #(.DEPTH(DEPTH)) bus ();

  to_unsigned_buf #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [15:0] d;
    logic        req;
    logic        clr;
    logic [15:0] e_od;
    logic        e_re;
    int          e_lvl;
    logic        e_ovf;
    logic        e_udr;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_od;
  logic        m_re, m_ovf, m_udr;

  function automatic void add(input logic r, input logic we, input logic [15:0] d,
                              input logic req, input logic clr, input logic [15:0] eod,
                              input logic ere, input int elvl, input logic eovf, input logic eudr);
    vec_t v;
    v.rst_n = r; v.we = we; v.d = d; v.req = req; v.clr = clr;
    v.e_od = eod; v.e_re = ere; v.e_lvl = elvl; v.e_ovf = eovf; v.e_udr = eudr;
    tbl.push_back(v);
  endfunction

  // Non-negative samples sit above mid-scale; negative ones mirror below it.
  function automatic logic [15:0] ref_map(input logic [15:0] d);
    int s;
    s = $signed(d);
    if (s >= 0) return 16'(32768 + s);
    else        return 16'(-1 - s);
  endfunction

  task automatic model_step(input logic r, input logic we, input logic [15:0] d,
                            input logic req, input logic clr);
    int  n;
    logic ovf_ev, udr_ev;
    if (!r) begin
      mq.delete();
      m_od = 16'h8000; m_re = 1'b0; m_ovf = 1'b0; m_udr = 1'b0;
    end else begin
      n = mq.size();
      ovf_ev = 1'b0; udr_ev = 1'b0;
      m_re = req;
      if (req) begin
        if (n == 0) begin m_od = 16'h8000; udr_ev = 1'b1; end
        else m_od = mq.pop_front();
      end
      if (we) begin
        if (n < DEPTH || req) mq.push_back(ref_map(d));
        else ovf_ev = 1'b1;
      end
      m_ovf = ovf_ev | (m_ovf & ~clr);
      m_udr = udr_ev | (m_udr & ~clr);
    end
  endtask

  task automatic apply(input logic r, input logic we, input logic [15:0] d,
                       input logic req, input logic clr);
    rst_n = r; bus.we = we; bus.i_data = d; bus.req = req; bus.clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic [15:0] eod, input logic ere,
                         input int elvl, input logic eovf, input logic eudr);
    logic efull, eempty;
    efull  = (elvl == DEPTH);
    eempty = (elvl == 0);
    n_vec++;
    if (bus.o_data !== eod || bus.re !== ere || int'(bus.level) != elvl ||
        bus.full !== efull || bus.empty !== eempty || bus.ovf !== eovf || bus.udr !== eudr) begin
      n_err++;
      $display("FAIL %s: got od=%h re=%b lvl=%0d full=%b empty=%b ovf=%b udr=%b, expected od=%h re=%b lvl=%0d full=%b empty=%b ovf=%b udr=%b",
               name, bus.o_data, bus.re, bus.level, bus.full, bus.empty, bus.ovf, bus.udr,
               eod, ere, elvl, efull, eempty, eovf, eudr);
    end
  endtask

  initial begin
    logic [15:0] t2_in  [4];
    logic [15:0] t2_out [4];
    logic r, we, req, clr;
    logic [15:0] d;
    int we_pct, req_pct;

    rst_n = 1'b0; bus.we = 1'b0; bus.i_data = '0; bus.req = 1'b0; bus.clr = 1'b0;
    t2_in  = '{16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
    t2_out = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};

    // Reset state
    add(0,0,0,0,0, 16'h8000,0,0,0,0);
    add(0,0,0,0,0, 16'h8000,0,0,0,0);
    // Underrun from reset, then clear
    add(1,0,0,1,0, 16'h8000,1,0,0,1);
    add(1,0,0,0,0, 16'h8000,0,0,0,1);
    add(1,0,0,0,1, 16'h8000,0,0,0,0);
    // Mapping fixed points
    for (int i = 0; i < 4; i++) add(1,1,t2_in[i],0,0, 16'h8000,0,i+1,0,0);
    for (int i = 0; i < 4; i++) add(1,0,0,1,0, t2_out[i],1,3-i,0,0);
    add(1,0,0,0,0, 16'h7FFF,0,0,0,0);
    // Overflow on DEPTH+1 writes, drain in order
    for (int i = 1; i <= 8; i++) add(1,1,16'(i),0,0, 16'h7FFF,0,i,0,0);
    add(1,1,16'd9,0,0, 16'h7FFF,0,8,1,0);
    for (int i = 1; i <= 8; i++) add(1,0,0,1,0, 16'(16'h8000 + i),1,8-i,1,0);
    add(1,0,0,0,1, 16'h8008,0,0,0,0);
    // Write and read together while full
    for (int i = 1; i <= 8; i++) add(1,1,16'(i),0,0, 16'h8008,0,i,0,0);
    add(1,1,16'h1234,1,0, 16'h8001,1,8,0,0);
    for (int i = 2; i <= 8; i++) add(1,0,0,1,0, 16'(16'h8000 + i),1,9-i,0,0);
    add(1,0,0,1,0, 16'h9234,1,0,0,0);
    // Write and read together while empty
    add(1,1,16'h0001,1,0, 16'h8000,1,1,0,1);
    add(1,0,0,1,0, 16'h8001,1,0,0,1);
    // Mid-stream reset with we/req in the reset cycle
    for (int i = 1; i <= 5; i++) add(1,1,16'(i),0,0, 16'h8001,0,i,0,1);
    add(0,1,16'h0055,1,0, 16'h8000,0,0,0,0);
    add(1,0,0,1,0, 16'h8000,1,0,0,1);
    // Sticky flag clear, and event beating clr
    for (int i = 1; i <= 8; i++) add(1,1,16'(i),0,0, 16'h8000,0,i,0,1);
    add(1,1,16'd9,0,0, 16'h8000,0,8,1,1);
    add(1,1,16'd10,0,1, 16'h8000,0,8,1,0);
    add(1,0,0,0,1, 16'h8000,0,8,0,0);
    for (int i = 1; i <= 8; i++) add(1,0,0,1,0, 16'(16'h8000 + i),1,8-i,0,0);
    add(1,0,0,1,1, 16'h8000,1,0,0,1);
    add(1,0,0,0,1, 16'h8000,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst_n, tbl[i].we, tbl[i].d, tbl[i].req, tbl[i].clr);
      compare($sformatf("tbl%0d", i), tbl[i].e_od, tbl[i].e_re, tbl[i].e_lvl,
              tbl[i].e_ovf, tbl[i].e_udr);
    end

    // Random traffic against the reference model, with shifting write/read pressure
    model_step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    compare("rnd_rst", m_od, m_re, mq.size(), m_ovf, m_udr);
    for (int c = 0; c < 3000; c++) begin
      we_pct  = (c < 1000) ? 75 : (c < 2000) ? 35 : 55;
      req_pct = (c < 1000) ? 35 : (c < 2000) ? 75 : 55;
      r   = ($urandom_range(0, 199) != 0);
      we  = ($urandom_range(0, 99) < we_pct);
      req = ($urandom_range(0, 99) < req_pct);
      clr = ($urandom_range(0, 15) == 0);
      d   = 16'($urandom);
      model_step(r, we, d, req, clr);
      apply(r, we, d, req, clr);
      compare($sformatf("rnd%0d", c), m_od, m_re, mq.size(), m_ovf, m_udr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
